// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage -- write-back stage of a five-stage in-order pipeline.
//
// Holds one instruction from MEM, writes it into the register file when it
// commits, forwards its destination to ID for RAW hazard detection, counts
// retired instructions and publishes a commit trace on the debug_* ports.
//
// Optional feature (macro WB_TRACE_FIFO_EN):
//   undefined : debug_* is driven combinationally from the WB register,
//               the stage never stalls and debug_wb_ready is ignored.
//   defined   : commits are pushed into a 4-entry trace FIFO. The stage
//               stalls while the FIFO is full, so no trace entry is lost.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   mem_to_wb_valid/bus  incoming instruction {regW, regWAddr, regWData, pc}
//   wb_allowin           WB can accept an instruction this cycle
//   rf_we/waddr/wdata    register-file write port
//   wb_to_id_bus         {we, waddr, wdata} forwarded to ID
//   debug_wb_*           commit trace (valid/ready handshake)
//   wb_retire_cnt        number of committed instructions, wraps at 2^32
// ---------------------------------------------------------------------------
module wb_stage (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_to_wb_valid,
   input  logic [69:0] mem_to_wb_bus,
   output logic        wb_allowin,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic [37:0] wb_to_id_bus,
   output logic [31:0] debug_wb_pc,
   output logic [3:0]  debug_wb_rf_we,
   output logic [4:0]  debug_wb_rf_wnum,
   output logic [31:0] debug_wb_rf_wdata,
   output logic        debug_wb_valid,
   input  logic        debug_wb_ready,
   output logic [31:0] wb_retire_cnt
);

   typedef struct packed {
      logic        reg_w;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [31:0] pc;
   } wb_data_t;

   logic        wb_valid_q, wb_valid_d;
   wb_data_t    wb_data_q, wb_data_d;
   logic [31:0] retire_cnt_q, retire_cnt_d;
   logic        wb_ready_go;
   logic        commit;
   logic        wr_nonzero;

   assign wr_nonzero  = wb_data_q.reg_w & (wb_data_q.waddr != 5'd0);
   assign commit      = wb_valid_q & wb_ready_go;
   assign wb_allowin  = ~wb_valid_q | wb_ready_go;

   always_comb begin
      wb_valid_d   = wb_valid_q;
      wb_data_d    = wb_data_q;
      retire_cnt_d = retire_cnt_q;
      if (wb_allowin) begin
         wb_valid_d = mem_to_wb_valid;
         if (mem_to_wb_valid) wb_data_d = wb_data_t'(mem_to_wb_bus);
      end
      if (commit) retire_cnt_d = retire_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wb_valid_q   <= 1'b0;
         retire_cnt_q <= 32'd0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every flop
         // samples its _d value from before the edge.
         wb_valid_q   <= wb_valid_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   // NOTE: the payload has no reset; everything read from it is qualified by
   // wb_valid_q, so resetting it would only add reset fanout.
   always_ff @(posedge clk) begin
      wb_data_q <= wb_data_d;
   end

   assign rf_we         = commit & wr_nonzero;
   assign rf_waddr      = wb_data_q.waddr;
   assign rf_wdata      = wb_data_q.wdata;
   assign wb_retire_cnt = retire_cnt_q;

   // Forwarding ignores wb_ready_go: a stalled instruction still owns its
   // destination and ID must see it.
   assign wb_to_id_bus = {wb_valid_q & wb_data_q.reg_w,
                          wb_valid_q ? wb_data_q.waddr : 5'd0,
                          wb_data_q.wdata};

`ifdef WB_TRACE_FIFO_EN
   typedef struct packed {
      logic [31:0] pc;
      logic        we;
      logic [4:0]  wnum;
      logic [31:0] wdata;
   } trace_t;

   trace_t     fifo_q [4];
   trace_t     fifo_d [4];
   logic [1:0] wr_ptr_q, wr_ptr_d;
   logic [1:0] rd_ptr_q, rd_ptr_d;
   logic [2:0] cnt_q, cnt_d;
   logic       push, pop;

   // Stall decision comes from the registered count only, so a pop in the
   // same cycle cannot open a combinational path from debug_wb_ready.
   assign wb_ready_go = (cnt_q != 3'd4);
   assign push        = commit;
   assign pop         = debug_wb_valid & debug_wb_ready;

   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         fifo_d[wr_ptr_q] = '{pc:    wb_data_q.pc,
                              we:    wr_nonzero,
                              wnum:  wb_data_q.waddr,
                              wdata: wb_data_q.wdata};
         wr_ptr_d = wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 3'd1;
         2'b01:   cnt_d = cnt_q - 3'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         cnt_q    <= 3'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end

   assign debug_wb_valid    = (cnt_q != 3'd0);
   assign debug_wb_pc       = fifo_q[rd_ptr_q].pc;
   assign debug_wb_rf_we    = {4{fifo_q[rd_ptr_q].we}};
   assign debug_wb_rf_wnum  = fifo_q[rd_ptr_q].wnum;
   assign debug_wb_rf_wdata = fifo_q[rd_ptr_q].wdata;
`else
   // Without buffering the trace consumer cannot back-pressure WB.
   logic unused_debug_ready;
   assign unused_debug_ready = debug_wb_ready;

   assign wb_ready_go       = 1'b1;
   assign debug_wb_valid    = wb_valid_q;
   assign debug_wb_pc       = wb_data_q.pc;
   assign debug_wb_rf_we    = {4{wb_valid_q & wr_nonzero}};
   assign debug_wb_rf_wnum  = wb_data_q.waddr;
   assign debug_wb_rf_wdata = wb_data_q.wdata;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage -- directed self-checking bench for wb_stage.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        resetn;
   logic        mem_to_wb_valid;
   logic [69:0] mem_to_wb_bus;
   logic        wb_allowin;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [37:0] wb_to_id_bus;
   logic [31:0] debug_wb_pc;
   logic [3:0]  debug_wb_rf_we;
   logic [4:0]  debug_wb_rf_wnum;
   logic [31:0] debug_wb_rf_wdata;
   logic        debug_wb_valid;
   logic        debug_wb_ready;
   logic [31:0] wb_retire_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   wb_stage dut (
      .clk               (clk),
      .resetn            (resetn),
      .mem_to_wb_valid   (mem_to_wb_valid),
      .mem_to_wb_bus     (mem_to_wb_bus),
      .wb_allowin        (wb_allowin),
      .rf_we             (rf_we),
      .rf_waddr          (rf_waddr),
      .rf_wdata          (rf_wdata),
      .wb_to_id_bus      (wb_to_id_bus),
      .debug_wb_pc       (debug_wb_pc),
      .debug_wb_rf_we    (debug_wb_rf_we),
      .debug_wb_rf_wnum  (debug_wb_rf_wnum),
      .debug_wb_rf_wdata (debug_wb_rf_wdata),
      .debug_wb_valid    (debug_wb_valid),
      .debug_wb_ready    (debug_wb_ready),
      .wb_retire_cnt     (wb_retire_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [69:0] mk(input logic w, input logic [4:0] a,
                                      input logic [31:0] d, input logic [31:0] pc);
      return {w, a, d, pc};
   endfunction

   task automatic drive(input logic [69:0] bus);
      mem_to_wb_valid = 1'b1;
      mem_to_wb_bus   = bus;
   endtask

   task automatic idle();
      mem_to_wb_valid = 1'b0;
      mem_to_wb_bus   = '0;
   endtask

`ifdef WB_TRACE_FIFO_EN
   // Five back-to-back commits with the trace consumer stalled; leaves the
   // FIFO full and the fifth instruction (pc 0x1C00_0010) held in WB.
   task automatic fill5();
      debug_wb_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(mk(1'b1, 5'(i + 1), 32'(i * 16 + 1), 32'h1C00_0000 + 32'(i * 4)));
         @(negedge clk);
      end
      idle();
   endtask
`endif

   initial begin
      resetn          = 1'b0;
      debug_wb_ready  = 1'b1;
      idle();

      // ---- reset state ----
      repeat (2) @(negedge clk);
      check("rst_allowin",    70'(wb_allowin), 70'd1);
      check("rst_rf_we",      70'(rf_we), 70'd0);
      check("rst_dbg_valid",  70'(debug_wb_valid), 70'd0);
      check("rst_dbg_we",     70'(debug_wb_rf_we), 70'd0);
      check("rst_retire",     70'(wb_retire_cnt), 70'd0);
      check("rst_fwd_we",     70'(wb_to_id_bus[37]), 70'd0);
      resetn = 1'b1;
      @(negedge clk);

      // ---- single add to r3 ----
      drive(mk(1'b1, 5'd3, 32'h0000_00AA, 32'h1C00_0000));
      @(negedge clk);
      idle();
      check("add_rf_we",    70'(rf_we), 70'd1);
      check("add_waddr",    70'(rf_waddr), 70'd3);
      check("add_wdata",    70'(rf_wdata), 70'hAA);
      check("add_fwd",      70'(wb_to_id_bus), 70'({1'b1, 5'd3, 32'h0000_00AA}));
      check("add_cnt_pre",  70'(wb_retire_cnt), 70'd0);
`ifndef WB_TRACE_FIFO_EN
      check("add_dbg_valid", 70'(debug_wb_valid), 70'd1);
      check("add_dbg_pc",    70'(debug_wb_pc), 70'h1C00_0000);
      check("add_dbg_we",    70'(debug_wb_rf_we), 70'hF);
      check("add_dbg_wnum",  70'(debug_wb_rf_wnum), 70'd3);
      check("add_dbg_wdata", 70'(debug_wb_rf_wdata), 70'hAA);
`endif
      @(negedge clk);
      check("add_cnt",      70'(wb_retire_cnt), 70'd1);
      check("add_rf_we_off", 70'(rf_we), 70'd0);
      check("idle_fwd_we",  70'(wb_to_id_bus[37]), 70'd0);
      check("idle_fwd_addr", 70'(wb_to_id_bus[36:32]), 70'd0);
`ifndef WB_TRACE_FIFO_EN
      check("idle_dbg_valid", 70'(debug_wb_valid), 70'd0);
      check("idle_dbg_we",    70'(debug_wb_rf_we), 70'd0);
`else
      // Trace entry appears one cycle after the commit.
      check("fifo_dbg_valid", 70'(debug_wb_valid), 70'd1);
      check("fifo_dbg_pc",    70'(debug_wb_pc), 70'h1C00_0000);
      check("fifo_dbg_we",    70'(debug_wb_rf_we), 70'hF);
`endif

      // ---- write to r0 is suppressed but still retires ----
      drive(mk(1'b1, 5'd0, 32'hFFFF_FFFF, 32'h1C00_0004));
      @(negedge clk);
      idle();
      check("r0_rf_we",   70'(rf_we), 70'd0);
      check("r0_fwd_we",  70'(wb_to_id_bus[37]), 70'd1);
`ifndef WB_TRACE_FIFO_EN
      check("r0_dbg_we",  70'(debug_wb_rf_we), 70'd0);
      check("r0_dbg_valid", 70'(debug_wb_valid), 70'd1);
`endif
      @(negedge clk);
      check("r0_cnt",     70'(wb_retire_cnt), 70'd2);

      // ---- regW=0: no write, address still presented ----
      drive(mk(1'b0, 5'd7, 32'h1234_5678, 32'h1C00_0008));
      @(negedge clk);
      idle();
      check("now_rf_we",  70'(rf_we), 70'd0);
      check("now_waddr",  70'(rf_waddr), 70'd7);
      check("now_fwd",    70'(wb_to_id_bus), 70'({1'b0, 5'd7, 32'h1234_5678}));
      @(negedge clk);
      check("now_cnt",    70'(wb_retire_cnt), 70'd3);

      // ---- three back-to-back writes ----
      for (int i = 0; i < 3; i++) begin
         drive(mk(1'b1, 5'(10 + i), 32'hA000_0000 + 32'(i), 32'h1C00_0100 + 32'(i * 4)));
         @(negedge clk);
         check("b2b_rf_we",  70'(rf_we), 70'd1);
         check("b2b_waddr",  70'(rf_waddr), 70'(10 + i));
         check("b2b_wdata",  70'(rf_wdata), 70'(32'hA000_0000 + 32'(i)));
         check("b2b_allow",  70'(wb_allowin), 70'd1);
      end
      idle();
      @(negedge clk);
      check("b2b_cnt",    70'(wb_retire_cnt), 70'd6);
      repeat (3) @(negedge clk);

      // ---- retire counter wrap ----
      dut.retire_cnt_q = 32'hFFFF_FFFF;
      drive(mk(1'b1, 5'd4, 32'h5, 32'h1C00_0200));
      @(negedge clk);
      idle();
      check("wrap_pre",   70'(wb_retire_cnt), 70'hFFFF_FFFF);
      @(negedge clk);
      check("wrap_cnt",   70'(wb_retire_cnt), 70'd0);
      repeat (3) @(negedge clk);

      // ---- reset while an instruction sits in WB ----
      drive(mk(1'b1, 5'd9, 32'h99, 32'h1C00_0300));
      @(negedge clk);
      idle();
      check("rmid_rf_we_pre", 70'(rf_we), 70'd1);
      resetn = 1'b0;
      #1;
      check("rmid_rf_we",   70'(rf_we), 70'd0);
      check("rmid_allow",   70'(wb_allowin), 70'd1);
      check("rmid_cnt",     70'(wb_retire_cnt), 70'd0);
      check("rmid_dbg",     70'(debug_wb_valid), 70'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

`ifdef WB_TRACE_FIFO_EN
      // ---- FIFO full: 4 commit, 5th held ----
      begin
         int idx;
         int we_seen;
         fill5();
         check("full_allow",  70'(wb_allowin), 70'd0);
         check("full_rf_we",  70'(rf_we), 70'd0);
         check("full_cnt",    70'(wb_retire_cnt), 70'd4);
         check("full_head",   70'(debug_wb_pc), 70'h1C00_0000);
         @(negedge clk);
         check("full_hold",   70'(rf_we), 70'd0);
         debug_wb_ready = 1'b1;
         idx = 0;
         we_seen = 0;
         for (int c = 0; c < 20; c++) begin
            if (rf_we) begin
               we_seen++;
               check("drain_waddr", 70'(rf_waddr), 70'd5);
            end
            if (debug_wb_valid) begin
               check("drain_pc", 70'(debug_wb_pc), 70'(32'h1C00_0000 + 32'(idx * 4)));
               idx++;
            end
            @(negedge clk);
         end
         check("drain_n",     70'(idx), 70'd5);
         check("drain_we",    70'(we_seen), 70'd1);
         check("drain_cnt",   70'(wb_retire_cnt), 70'd5);
      end

      // ---- reset while stalled with a full FIFO ----
      fill5();
      check("rfull_allow_pre", 70'(wb_allowin), 70'd0);
      resetn = 1'b0;
      #1;
      check("rfull_dbg",   70'(debug_wb_valid), 70'd0);
      check("rfull_allow", 70'(wb_allowin), 70'd1);
      check("rfull_cnt",   70'(wb_retire_cnt), 70'd0);
      check("rfull_we",    70'(rf_we), 70'd0);
      @(negedge clk);
      resetn = 1'b1;
      debug_wb_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rfull_never", 70'(rf_we), 70'd0);

      // ---- simultaneous push and pop at count 2 ----
      debug_wb_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(mk(1'b1, 5'd1, 32'd0, 32'h0000_0100 + 32'(i * 4)));
         @(negedge clk);
      end
      idle();
      check("pp_cnt_pre",  70'(dut.cnt_q), 70'd2);
      check("pp_head_pre", 70'(debug_wb_pc), 70'h100);
      debug_wb_ready = 1'b1;
      @(negedge clk);
      check("pp_cnt",      70'(dut.cnt_q), 70'd2);
      check("pp_head",     70'(debug_wb_pc), 70'h104);
      repeat (4) @(negedge clk);
      check("pp_empty",    70'(debug_wb_valid), 70'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
